// File: rtl/seg_display_mux.sv
// seg_display_mux: 4-digit time-multiplexed scanner for a common-anode
// seven-segment display. It keeps a tear-free shadow copy of four 4-bit
// codes, scans the digits one slot at a time, and drives the active-low
// anodes plus the code for the lit digit. Every digit change starts with a
// short all-anodes-off gap to suppress ghosting.
//
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to show leading zero
// digits (d3..d1) as blank (4'hF). Without it, all nibbles are shown verbatim.

module seg_display_mux #(
    parameter int DIGIT_CYCLES = 100_000,  // clocks per digit slot, >= 2
    parameter int BLANK_CYCLES = 1_000     // dark clocks at slot start, < DIGIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic        load,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an,
    output logic [3:0]  bcd,
    output logic        frame_start,
    output logic        busy
);

    localparam int CNT_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
    localparam logic [15:0]      ALL_BLANK = 16'hFFFF;

    // Scan position
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;

    // Update handshake state
    logic [15:0] pending_q, pending_d;
    logic [15:0] shadow_q, shadow_d;
    logic        busy_q, busy_d;

    // Registered outputs
    logic [3:0] an_q, an_d;
    logic [3:0] bcd_q, bcd_d;
    logic       fs_q, fs_d;

    // Last clock of the digit-3 slot: the only place the shadow may change.
    logic frame_end;
    assign frame_end = (idx_q == 2'd3) && (cnt_q == CNT_LAST);

    // Replace leading zero digits with blank codes; d0 always stays visible.
    function automatic logic [15:0] lead_zero_blank(input logic [15:0] w);
        logic [15:0] r;
        r = w;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (w[15:12] == 4'h0) begin
            r[15:12] = 4'hF;
            if (w[11:8] == 4'h0) begin
                r[11:8] = 4'hF;
                if (w[7:4] == 4'h0) begin
                    r[7:4] = 4'hF;
                end
            end
        end
`endif
        return r;
    endfunction

    // Pick the nibble for one digit position out of a packed 4-digit word.
    function automatic logic [3:0] nibble_sel(input logic [15:0] w, input logic [1:0] sel);
        logic [3:0] n;
        case (sel)
            2'd0:    n = w[3:0];
            2'd1:    n = w[7:4];
            2'd2:    n = w[11:8];
            default: n = w[15:12];
        endcase
        return n;
    endfunction

    // Slot counter wraps every DIGIT_CYCLES clocks and steps the digit index.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Pending/shadow handshake: updates land only at the frame boundary,
    // and a load on the boundary itself goes straight to the shadow.
    always_comb begin
        pending_d = pending_q;
        shadow_d  = shadow_q;
        busy_d    = busy_q;
        if (load) begin
            pending_d = digits;
            if (frame_end) begin
                shadow_d = digits;
                busy_d   = 1'b0;
            end else begin
                busy_d   = 1'b1;
            end
        end else if (frame_end && busy_q) begin
            shadow_d = pending_q;
            busy_d   = 1'b0;
        end
    end

    // Output decode for the current (idx, cnt): the code tracks the slot from
    // its first clock, while the anode stays off during the anti-ghost gap.
    always_comb begin
        logic [15:0] disp;
        logic        en;
        logic        gap;
        disp  = lead_zero_blank(shadow_q);
        en    = digit_en[idx_q];
        gap   = (cnt_q < BLANK_LIM);
        an_d  = 4'b1111;
        bcd_d = 4'hF;
        fs_d  = (idx_q == 2'd0) && (cnt_q == '0);
        if (en) begin
            bcd_d = nibble_sel(disp, idx_q);
            if (!gap) begin
                an_d = ~(4'b0001 << idx_q);
            end
        end
    end

    // State and output registers; reset blanks the display and drops any
    // pending update.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            pending_q <= ALL_BLANK;
            shadow_q  <= ALL_BLANK;
            busy_q    <= 1'b0;
            an_q      <= 4'b1111;
            bcd_q     <= 4'hF;
            fs_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            busy_q    <= busy_d;
            an_q      <= an_d;
            bcd_q     <= bcd_d;
            fs_q      <= fs_d;
        end
    end

    assign an          = an_q;
    assign bcd         = bcd_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux with short slots (4 clocks, 1 blank clock).
// A position-based reference model predicts every output on every clock.

module tb_seg_display_mux;

    localparam int DC = 4;
    localparam int BC = 1;
    localparam int FR = 4 * DC;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  digit_en;
    logic [3:0]  an;
    logic [3:0]  bcd;
    logic        frame_start;
    logic        busy;

    always #5 clk = ~clk;

    seg_display_mux #(
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits),
        .load        (load),
        .digit_en    (digit_en),
        .an          (an),
        .bcd         (bcd),
        .frame_start (frame_start),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: clocks since reset release, displayed word, pending word.
    int          p;
    logic [15:0] sh_m;
    logic [15:0] pend_m;
    logic        busy_m;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t, pos=%0d)", tag, got, exp, $time, p);
        end
    endtask

    function automatic logic [15:0] shown(input logic [15:0] w);
        logic [15:0] r;
        r = w;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        for (int i = 3; i >= 1; i--) begin
            if (r[i*4 +: 4] == 4'h0) r[i*4 +: 4] = 4'hF;
            else break;
        end
`endif
        return r;
    endfunction

    // One clock: apply load/digits, then compare all outputs with the model.
    task automatic step(input logic ld, input logic [15:0] dg);
        int          cnt;
        int          idx;
        logic [15:0] disp;
        logic [3:0]  e_an;
        logic [3:0]  e_bcd;
        logic        e_fs;
        load   = ld;
        digits = dg;
        @(posedge clk);
        #1;
        if (rst) begin
            p      = 0;
            sh_m   = 16'hFFFF;
            pend_m = 16'hFFFF;
            busy_m = 1'b0;
            e_an   = 4'b1111;
            e_bcd  = 4'hF;
            e_fs   = 1'b0;
        end else begin
            cnt  = p % DC;
            idx  = (p / DC) % 4;
            disp = shown(sh_m);
            e_fs = (p % FR == 0);
            if (!digit_en[idx]) begin
                e_an  = 4'b1111;
                e_bcd = 4'hF;
            end else begin
                e_bcd = disp[idx*4 +: 4];
                e_an  = (cnt < BC) ? 4'b1111 : ~(4'b0001 << idx);
            end
            if (ld) begin
                if (p % FR == FR - 1) begin
                    sh_m   = dg;
                    busy_m = 1'b0;
                end else begin
                    pend_m = dg;
                    busy_m = 1'b1;
                end
            end else if ((p % FR == FR - 1) && busy_m) begin
                sh_m   = pend_m;
                busy_m = 1'b0;
            end
            p++;
        end
        check("an", {12'h0, an}, {12'h0, e_an});
        check("bcd", {12'h0, bcd}, {12'h0, e_bcd});
        check("frame_start", {15'h0, frame_start}, {15'h0, e_fs});
        check("busy", {15'h0, busy}, {15'h0, busy_m});
        load = 1'b0;
    endtask

    // Idle until the next clock will be at frame position pos.
    task automatic align_to(input int pos);
        for (int k = 0; k < FR && (p % FR) != pos; k++) step(1'b0, 16'h0);
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        digits   = 16'h0;
        digit_en = 4'hF;
        p        = 0;
        sh_m     = 16'hFFFF;
        pend_m   = 16'hFFFF;
        busy_m   = 1'b0;

        // Reset held, then one blank frame
        repeat (3) step(1'b0, 16'h0);
        rst = 1'b0;
        repeat (FR) step(1'b0, 16'h0);

        // Mid-frame load
        align_to(5);
        step(1'b1, 16'h1234);
        repeat (2 * FR) step(1'b0, 16'h0);

        // Two loads in one frame: only the last is shown
        align_to(1);
        step(1'b1, 16'h5678);
        repeat (3) step(1'b0, 16'h0);
        step(1'b1, 16'h9ABC);
        repeat (2 * FR) step(1'b0, 16'h0);

        // Load on the boundary cycle goes straight through
        align_to(FR - 1);
        step(1'b1, 16'hDCBE);
        repeat (FR + 1) step(1'b0, 16'h0);

        // Per-digit enables
        step(1'b1, 16'h1234);
        repeat (2 * FR) step(1'b0, 16'h0);
        digit_en = 4'b0101;
        repeat (FR) step(1'b0, 16'h0);
        digit_en = 4'hF;

        // Leading zeros (blanked only with the option)
        step(1'b1, 16'h0040);
        repeat (2 * FR) step(1'b0, 16'h0);

        // Reset during the idx=2 slot with an update pending
        align_to(2 * DC + 1);
        step(1'b1, 16'hABCD);
        rst = 1'b1;
        step(1'b0, 16'h0);
        rst = 1'b0;
        repeat (FR + 2) step(1'b0, 16'h0);
        step(1'b1, 16'h0000);
        repeat (2 * FR) step(1'b0, 16'h0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) == 0) digit_en = 4'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            step($urandom_range(0, 5) == 0, 16'($urandom));
        end
        rst = 1'b0;
        repeat (FR) step(1'b0, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
